// File: rtl/or_x_taint_stage_pkg.sv
// Shared types and the OR-with-taint rule for the or_x_taint stage.
// The rule is shared by the stage and any combinational OR model.
package or_x_taint_stage_pkg;

    localparam int TAINT_W_DEF = 32;

    typedef logic [TAINT_W_DEF-1:0] taint_t;

    // Returns {c, c_t}. A definite 1 on one side alone dominates the taint.
    // Any other case (both 1, any X, both 0) takes the union.
    function automatic logic [TAINT_W_DEF:0] or_taint(
        input logic   a,
        input taint_t a_t,
        input logic   b,
        input taint_t b_t
    );
        taint_t t;
        if (a === 1'b1 && b !== 1'b1) begin
            t = a_t;
        end else if (b === 1'b1 && a !== 1'b1) begin
            t = b_t;
        end else begin
            t = a_t | b_t;
        end
        return {a | b, t};
    endfunction

endpackage

// File: rtl/or_x_taint_stage_fifo.sv
// Generic DEPTH x W storage with wrap-around pointers and occupancy.
// Read data is forced to zero while empty so nothing stale leaks out.
module or_x_taint_stage_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr];

    // Entry storage; contents are not reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/or_x_taint_stage.sv
// Buffered OR-with-taint stage: result and taint computed at push,
// queued in order, with pop counting and a sticky taint summary.
module or_x_taint_stage
    import or_x_taint_stage_pkg::*;
#(
    parameter int TAINT_W = TAINT_W_DEF,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int LW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               a,
    input  logic [TAINT_W-1:0] a_t,
    input  logic               b,
    input  logic [TAINT_W-1:0] b_t,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               c,
    output logic [TAINT_W-1:0] c_t,
    output logic [LW-1:0]      level,
    output logic [CNT_W-1:0]   pop_cnt,
    output logic [TAINT_W-1:0] taint_seen
);

    logic [TAINT_W_DEF:0] res;
    logic [TAINT_W:0]     wdata;
    logic [TAINT_W:0]     rdata;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign res   = or_taint(a, taint_t'(a_t), b, taint_t'(b_t));
    assign wdata = {res[TAINT_W_DEF], res[TAINT_W-1:0]};

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign c         = rdata[TAINT_W];
    assign c_t       = rdata[TAINT_W-1:0];

    or_x_taint_stage_fifo #(
        .W     (TAINT_W + 1),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Pop accounting: wrapping count and sticky union of delivered taint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt    <= '0;
            taint_seen <= '0;
        end else if (pop) begin
            pop_cnt    <= pop_cnt + CNT_W'(1);
            taint_seen <= taint_seen | c_t;
        end
    end

endmodule

// File: tb/tb_or_x_taint_stage.sv
// Self-checking bench for or_x_taint_stage using a scoreboard queue
// filled on accepted pushes and consumed on accepted pops.
module tb_or_x_taint_stage;

    localparam int TW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int LW    = 3;

    typedef struct {
        logic          c;
        logic [TW-1:0] t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          a;
    logic [TW-1:0] a_t;
    logic          b;
    logic [TW-1:0] b_t;
    logic          out_valid;
    logic          out_ready;
    logic          c;
    logic [TW-1:0] c_t;
    logic [LW-1:0] level;
    logic [CW-1:0] pop_cnt;
    logic [TW-1:0] taint_seen;

    exp_t          q[$];
    logic [CW-1:0] m_cnt;
    logic [TW-1:0] m_seen;
    int            checks = 0;
    int            errors = 0;

    or_x_taint_stage #(
        .TAINT_W (TW),
        .DEPTH   (DEPTH),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .a_t        (a_t),
        .b          (b),
        .b_t        (b_t),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .c_t        (c_t),
        .level      (level),
        .pop_cnt    (pop_cnt),
        .taint_seen (taint_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: a lone definite 1 picks its own label, all else unions.
    function automatic exp_t model(input logic ma, input logic [TW-1:0] mat,
                                   input logic mb, input logic [TW-1:0] mbt);
        exp_t e;
        e.c = ma | mb;
        case ({ma === 1'b1, mb === 1'b1})
            2'b10:   e.t = mat;
            2'b01:   e.t = mbt;
            default: e.t = mat | mbt;
        endcase
        return e;
    endfunction

    // One clock: check visible state, update scoreboard, advance.
    task automatic tick();
        int n;
        n = q.size();
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
        chk("level", 64'(level), 64'(n));
        chk("pop_cnt", 64'(pop_cnt), 64'(m_cnt));
        chk("taint_seen", 64'(taint_seen), 64'(m_seen));
        if (n != 0) begin
            chk("c", 64'(c), 64'(q[0].c));
            chk("c_t", 64'(c_t), 64'(q[0].t));
        end else begin
            chk("c_empty", 64'(c), 64'd0);
            chk("c_t_empty", 64'(c_t), 64'd0);
        end
        if (n != 0 && out_ready) begin
            m_seen = m_seen | q[0].t;
            m_cnt  = m_cnt + 1'b1;
            void'(q.pop_front());
        end
        if (in_valid && n < DEPTH) begin
            q.push_back(model(a, a_t, b, b_t));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic [TW-1:0] vat,
                         input logic vb, input logic [TW-1:0] vbt);
        in_valid = 1'b1;
        a   = va;
        a_t = vat;
        b   = vb;
        b_t = vbt;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            tick();
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        a_t       = '0;
        b_t       = '0;
        m_cnt     = '0;
        m_seen    = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: basic push, one-cycle latency, pop accounting
        drive(1'b0, 32'd1, 1'b0, 32'd2);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_c", 64'(c), 64'd0);
        chk("t1_ct", 64'(c_t), 64'd3);
        out_ready = 1'b1;
        tick();
        chk("t1_cnt", 64'(pop_cnt), 64'd1);
        chk("t1_seen", 64'(taint_seen), 64'd3);

        // 2 and 3: X handling and taint selection, streamed
        drive(1'bx, 32'd1, 1'b1, 32'd2);
        drive(1'bx, 32'd1, 1'b0, 32'd2);
        drive(1'bx, 32'd1, 1'bx, 32'd2);
        drive(1'b1, 32'd1, 1'b1, 32'd2);
        drive(1'b1, 32'd4, 1'b0, 32'd8);
        drive(1'b0, 32'h10, 1'b1, 32'h20);
        drain();

        // 4: fill to full under backpressure, overflow ignored, drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 32'(1 << i), ~i[0], 32'(1 << (i + 8)));
        end
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_ready", 64'(in_ready), 64'd0);
        drain();
        chk("t4_cnt", 64'(pop_cnt), 64'(m_cnt));
        chk("t4_empty", 64'(out_valid), 64'd0);

        // 5: steady push+pop at level 2 across pointer wrap
        out_ready = 1'b0;
        drive(1'b0, 32'h100, 1'b0, 32'h200);
        drive(1'b1, 32'h400, 1'b0, 32'h800);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), $urandom);
            chk("t5_level", 64'(level), 64'd2);
        end
        drain();

        // 6: asynchronous reset with three entries queued
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b0, 32'd2);
        drive(1'b0, 32'd4, 1'b1, 32'd8);
        drive(1'b1, 32'd16, 1'b1, 32'd32);
        chk("t6_level3", 64'(level), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_c", 64'(c), 64'd0);
        chk("t6_ct", 64'(c_t), 64'd0);
        chk("t6_cnt", 64'(pop_cnt), 64'd0);
        chk("t6_seen", 64'(taint_seen), 64'd0);
        q.delete();
        m_cnt  = '0;
        m_seen = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 32'h5, 1'b1, 32'ha);
        chk("t6_after", 64'(out_valid), 64'd1);
        chk("t6_after_ct", 64'(c_t), 64'ha);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
